// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with valid/ready handshakes on both sides.
//
// Supported control codes: 0010 ADD, 0110 SUB, 0001 OR, 0011 AND. Any other
// code completes in one cycle with result=0 and inv_ctrl=1.
//
// Build option ALU_SHIFT_EN (macro): when defined, codes 1000 (SLL) and
// 1001 (SRL) become valid. They run one bit per cycle through a BUSY state
// and a shift-amount down-counter. When the macro is undefined, these codes
// are treated as invalid and no shift hardware is built.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake; alu_ctrl, op_a and op_b are
//                       captured on accept
//   op_b[SHW-1:0]       shift amount
//   out_valid/out_ready result handshake; result, zero, ovf and inv_ctrl
//                       stay stable while out_valid is high
module alu_exec_unit #(
    parameter int WIDTH = 64,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             inv_ctrl
);

    if (WIDTH < 8 || (1 << SHW) != WIDTH) begin : g_bad_width
        $error("alu_exec_unit: WIDTH must be a power of two >= 8");
    end

    localparam logic [3:0] CTRL_AND = 4'b0011;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
`ifdef ALU_SHIFT_EN
    localparam logic [3:0] CTRL_SLL = 4'b1000;
    localparam logic [3:0] CTRL_SRL = 4'b1001;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
`else
    typedef enum logic [0:0] {IDLE = 1'b0, DONE = 1'b1} state_t;
`endif

    state_t state, state_nxt, issue_state;

    logic             accept;
    logic [WIDTH-1:0] sum, diff;
    logic [WIDTH-1:0] calc_res;
    logic             calc_ovf, calc_inv, calc_multi;

    logic [WIDTH-1:0] result_q;
    logic             zero_q, ovf_q, inv_q;

`ifdef ALU_SHIFT_EN
    logic [WIDTH-1:0] shreg, shift_nxt;
    logic [SHW-1:0]   cnt;
    logic             dir_right;
`endif

    assign accept = in_valid && in_ready;
    assign sum    = op_a + op_b;
    assign diff   = op_a - op_b;

    // Operation decode; single-cycle codes produce their final result here.
    always_comb begin
        calc_res   = '0;
        calc_ovf   = 1'b0;
        calc_inv   = 1'b0;
        calc_multi = 1'b0;
        case (alu_ctrl)
            CTRL_ADD: begin
                calc_res = sum;
                calc_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                           (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            CTRL_SUB: begin
                calc_res = diff;
                calc_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                           (diff[WIDTH-1] != op_a[WIDTH-1]);
            end
            CTRL_OR:  calc_res = op_a | op_b;
            CTRL_AND: calc_res = op_a & op_b;
`ifdef ALU_SHIFT_EN
            // A zero shift amount completes immediately with op_a unchanged.
            CTRL_SLL, CTRL_SRL: begin
                calc_res   = op_a;
                calc_multi = (op_b[SHW-1:0] != '0);
            end
`endif
            default:  calc_inv = 1'b1;
        endcase
    end

`ifdef ALU_SHIFT_EN
    assign shift_nxt   = dir_right ? (shreg >> 1) : (shreg << 1);
    assign issue_state = calc_multi ? BUSY : DONE;
`else
    assign issue_state = DONE;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = issue_state;
            DONE: begin
                if (accept)         state_nxt = issue_state;
                else if (out_ready) state_nxt = IDLE;
            end
`ifdef ALU_SHIFT_EN
            BUSY: if (cnt == SHW'(1)) state_nxt = DONE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
        out_valid = (state == DONE);
        result    = result_q;
        zero      = zero_q;
        ovf       = ovf_q;
        inv_ctrl  = inv_q;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q  <= '0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            inv_q     <= 1'b0;
`ifdef ALU_SHIFT_EN
            shreg     <= '0;
            cnt       <= '0;
            dir_right <= 1'b0;
`endif
        end else begin
            if (accept) begin
`ifdef ALU_SHIFT_EN
                if (calc_multi) begin
                    shreg     <= op_a;
                    cnt       <= op_b[SHW-1:0];
                    dir_right <= (alu_ctrl == CTRL_SRL);
                end else
`endif
                begin
                    result_q <= calc_res;
                    zero_q   <= !calc_inv && (calc_res == '0);
                    ovf_q    <= calc_ovf;
                    inv_q    <= calc_inv;
                end
            end
`ifdef ALU_SHIFT_EN
            // The last shift step writes straight into the result register so
            // DONE presents the final value on the following cycle.
            else if (state == BUSY) begin
                shreg <= shift_nxt;
                cnt   <= cnt - SHW'(1);
                if (cnt == SHW'(1)) begin
                    result_q <= shift_nxt;
                    zero_q   <= (shift_nxt == '0);
                    ovf_q    <= 1'b0;
                    inv_q    <= 1'b0;
                end
            end
`endif
        end
    end

endmodule
